program_loader: RTL and testbench

- Byte-stream loader that fills the instruction RAM through its byte-wide write port (write_address / write_enable / write_data) and holds the core in reset until the image is complete and verified.
- Sits between the UART receiver (valid/ready byte stream) and the program memory write port.
- Parses a framed image: magic byte, 16-bit length, payload, then an 8-bit checksum.

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/program_loader_checksum.sv | 26 ++
 rtl/program_loader.sv | 149 ++++++++++++++
 tb/tb_program_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

    localparam int unsigned XLEN_WIDTH   = 32;
    localparam logic [7:0]  LOADER_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_MAGIC = 3'd1,
        LEN_LO     = 3'd2,
        LEN_HI     = 3'd3,
        PAYLOAD    = 3'd4,
        CHECK      = 3'd5,
        DONE       = 3'd6,
        ERROR      = 3'd7
    } loader_state_e;

    // States in which the loader consumes bytes from the receiver.
    function automatic logic is_receiving(input loader_state_e s);
        return s inside {WAIT_MAGIC, LEN_LO, LEN_HI, PAYLOAD, CHECK};
    endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit modular accumulator for the image checksum, with clear and enable.
module program_loader_checksum (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else if (clr_i) begin
            sum_q <= 8'h00;
        end else if (en_i) begin
            sum_q <= sum_q + data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Parses a framed program image from a byte stream, writes it into instruction RAM
// and holds the core in reset until the image checksum has been verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned           MEM_BYTES      = 1024,
    parameter logic [XLEN_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [7:0]            MAGIC          = LOADER_MAGIC,
    parameter bit                    START_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_write_enable,
    output logic [XLEN_WIDTH-1:0] mem_write_address,
    output logic [7:0]            mem_write_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned IDX_W = $clog2(MEM_BYTES + 1);

    loader_state_e         state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [XLEN_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  recv_q, done_q, error_q, hold_q;
    logic                  sum_clr, sum_en;
    logic [7:0]            sum;
    logic                  accept;

    assign accept = rx_valid && recv_q;

    program_loader_checksum u_checksum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (sum_clr),
        .en_i    (sum_en),
        .data_i  (rx_data),
        .sum_o   (sum)
    );

    always_comb begin
        // NOTE: every signal gets a default up front so no path through the case infers a latch.
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        idx_d    = idx_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        sum_clr  = 1'b0;
        sum_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_MAGIC;
            end
            WAIT_MAGIC: begin
                if (accept && rx_data == MAGIC) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, len_lo_q};
                    idx_d   = '0;
                    sum_clr = 1'b1;
                    if ({1'b0, len_d} > 17'(MEM_BYTES)) begin
                        state_d = ERROR;
                    end else if (len_d == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    addr_d = BASE_ADDR + XLEN_WIDTH'(idx_q);
                    data_d = rx_data;
                    sum_en = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                    if (17'(idx_q) + 17'd1 == {1'b0, len_q}) state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept) state_d = (rx_data == sum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) state_d = WAIT_MAGIC;
            end
            default: state_d = state_q;
        endcase
    end

    // Status outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (START_ON_RESET) state_q <= WAIT_MAGIC;
            else                state_q <= IDLE;
            len_lo_q <= 8'h00;
            len_q    <= 16'h0000;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= 8'h00;
            recv_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            recv_q   <= is_receiving(state_d);
            done_q   <= (state_d == DONE);
            error_q  <= (state_d == ERROR);
            hold_q   <= (state_d != DONE);
        end
    end

    assign rx_ready          = recv_q;
    assign busy              = recv_q;
    assign mem_write_enable  = wr_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = data_q;
    assign cpu_hold          = hold_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames for program_loader, checked against a frame-level parser model.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int MEM_BYTES = 1024;
    localparam int BASE      = 0;
    localparam int ST_BUSY   = 0;
    localparam int ST_DONE   = 1;
    localparam int ST_ERR    = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  mem_write_enable;
    logic [XLEN_WIDTH-1:0] mem_write_address;
    logic [7:0]            mem_write_data;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;

    program_loader #(
        .MEM_BYTES      (MEM_BYTES),
        .BASE_ADDR      (XLEN_WIDTH'(BASE)),
        .MAGIC          (LOADER_MAGIC),
        .START_ON_RESET (1'b1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .cpu_hold          (cpu_hold),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [7:0] data; } acc_t;

    wr_t        wr_q[$];
    wr_t        exp_q[$];
    acc_t       acc_q[$];
    logic [7:0] tx_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_st;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (mem_write_enable === 1'b1)
            wr_q.push_back(wr_t'{cyc, mem_write_address, mem_write_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parse the accepted byte sequence as a frame: expected writes and final status.
    task automatic run_model();
        int i = 0;
        int n = acc_q.size();
        int len;
        int sum = 0;
        exp_q.delete();
        exp_st = ST_BUSY;
        while (i < n && acc_q[i].data != LOADER_MAGIC) i++;
        if (i + 2 >= n) return;
        len = int'(acc_q[i+1].data) + 256 * int'(acc_q[i+2].data);
        i += 3;
        if (len > MEM_BYTES) begin
            exp_st = ST_ERR;
            return;
        end
        for (int k = 0; k < len && i + k < n; k++) begin
            exp_q.push_back(wr_t'{acc_q[i+k].cyc + 1, 32'(BASE + k), acc_q[i+k].data});
            sum += int'(acc_q[i+k].data);
        end
        if (i + len >= n) return;
        exp_st = (int'(acc_q[i+len].data) == sum % 256) ? ST_DONE : ST_ERR;
    endtask

    task automatic check_status(input string tag, input int st);
        check({tag, " done"},     32'(done),     32'(st == ST_DONE));
        check({tag, " error"},    32'(error),    32'(st == ST_ERR));
        check({tag, " cpu_hold"}, 32'(cpu_hold), 32'(st != ST_DONE));
        check({tag, " busy"},     32'(busy),     32'(st == ST_BUSY));
        check({tag, " rx_ready"}, 32'(rx_ready), 32'(st == ST_BUSY));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_ready"}, 32'(rx_ready),         32'd0);
        check({tag, " wr_en"},    32'(mem_write_enable), 32'd0);
        check({tag, " wr_addr"},  mem_write_address,     32'd0);
        check({tag, " wr_data"},  32'(mem_write_data),   32'd0);
        check({tag, " busy"},     32'(busy),             32'd0);
        check({tag, " done"},     32'(done),             32'd0);
        check({tag, " error"},    32'(error),            32'd0);
        check({tag, " cpu_hold"}, 32'(cpu_hold),         32'd1);
    endtask

    task automatic compare_frame(input string tag, input bit with_status);
        #1;
        run_model();
        check({tag, " write count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            check($sformatf("%s w%0d cycle", tag, k), 32'(wr_q[k].cyc), 32'(exp_q[k].cyc));
            check($sformatf("%s w%0d addr", tag, k),  wr_q[k].addr,      exp_q[k].addr);
            check($sformatf("%s w%0d data", tag, k),  32'(wr_q[k].data), 32'(exp_q[k].data));
        end
        if (with_status) check_status(tag, exp_st);
        if (with_status && exp_q.size() > 0) begin
            check({tag, " addr holds"}, mem_write_address, exp_q[exp_q.size()-1].addr);
            check({tag, " wr_en idle"}, 32'(mem_write_enable), 32'd0);
        end
    endtask

    task automatic new_frame();
        acc_q.delete();
        wr_q.delete();
        tx_q.delete();
    endtask

    // NOTE: the bench drives DUT inputs with blocking assignments, away from the sampling edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps) begin
            int g = 0;
            while ($urandom_range(0, 1) == 1 && g < 4) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
                g++;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("byte accepted", 32'(rx_ready), 32'd1);
        if (rx_ready === 1'b1) acc_q.push_back(acc_t'{cyc, b});
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_all(input bit gaps, input int start_at);
        foreach (tx_q[i]) begin
            if (i == start_at) pulse_start();
            send_byte(tx_q[i], gaps);
        end
    endtask

    task automatic rearm(input string tag);
        pulse_start();
        check({tag, " rearm error"},    32'(error),    32'd0);
        check({tag, " rearm done"},     32'(done),     32'd0);
        check({tag, " rearm cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, " rearm rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, " rearm busy"},     32'(busy),     32'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        reset_n = 1'b1;
        check("release rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("armed rx_ready", 32'(rx_ready), 32'd1);
        check("armed busy",     32'(busy),     32'd1);

        pulse_start();
        check("start ignored busy", 32'(busy), 32'd1);
        check("start ignored done", 32'(done), 32'd0);

        new_frame();
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        send_all(1'b0, -1);
        compare_frame("basic", 1'b1);

        wr_q.delete();
        rx_valid = 1'b1;
        rx_data  = LOADER_MAGIC;
        repeat (4) begin
            @(negedge clk);
            check("done holds rx_ready low", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        check("done no writes", 32'(wr_q.size()), 32'd0);
        check("done sticky", 32'(done), 32'd1);
        rearm("basic");

        new_frame();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04};
        send_all(1'b0, -1);
        compare_frame("badsum", 1'b1);
        rearm("badsum");

        new_frame();
        tx_q = '{8'hA5, 8'h01, 8'h04};
        send_all(1'b0, -1);
        compare_frame("oversize", 1'b1);
        rearm("oversize");

        new_frame();
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_all(1'b0, -1);
        compare_frame("zerolen", 1'b1);
        rearm("zerolen");

        new_frame();
        begin
            logic [7:0] s = 8'h00;
            tx_q = '{8'hA5, 8'h03, 8'h00};
            for (int k = 0; k < 3; k++) begin
                logic [7:0] b = 8'($urandom);
                tx_q.push_back(b);
                s = s + b;
            end
            tx_q.push_back(s);
        end
        send_all(1'b1, 4);
        compare_frame("flow", 1'b1);
        rearm("flow");

        new_frame();
        begin
            logic [7:0] s = 8'h00;
            tx_q = '{8'hA5, 8'h00, 8'h04};
            for (int k = 0; k < MEM_BYTES; k++) begin
                logic [7:0] b = 8'($urandom);
                tx_q.push_back(b);
                s = s + b;
            end
            tx_q.push_back(s);
        end
        send_all(1'b0, -1);
        compare_frame("maxlen", 1'b1);
        rearm("maxlen");

        for (int f = 0; f < 8; f++) begin
            int         len;
            int         nj;
            logic [7:0] s;
            logic [7:0] jb;
            new_frame();
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom);
                if (jb == LOADER_MAGIC) jb = 8'h5A;
                tx_q.push_back(jb);
            end
            len = $urandom_range(0, 40);
            if ($urandom_range(0, 5) == 0) len = MEM_BYTES + 1 + $urandom_range(0, 500);
            tx_q.push_back(LOADER_MAGIC);
            tx_q.push_back(8'(len));
            tx_q.push_back(8'(len >> 8));
            if (len <= MEM_BYTES) begin
                s = 8'h00;
                for (int k = 0; k < len; k++) begin
                    jb = 8'($urandom);
                    tx_q.push_back(jb);
                    s = s + jb;
                end
                if ($urandom_range(0, 1) == 1) s = s + 8'($urandom_range(1, 255));
                tx_q.push_back(s);
            end
            send_all(1'b1, -1);
            compare_frame($sformatf("rand%0d", f), 1'b1);
            rearm($sformatf("rand%0d", f));
        end

        new_frame();
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        for (int i = 0; i < 5; i++) send_byte(tx_q[i], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        compare_frame("midload partial", 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reload rx_ready", 32'(rx_ready), 32'd1);

        new_frame();
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        send_all(1'b0, -1);
        compare_frame("reload", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
